// File: rtl/vga_text_renderer_pkg.sv
// Shared types for the text-mode renderer: axis timing, IRGB
// attributes and the per-channel colour expansion.
package vga_text_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_axis_t;

    localparam vga_axis_t H_DEF = '{640, 16, 96, 48};
    localparam vga_axis_t V_DEF = '{480, 10, 2, 33};

    typedef struct packed {
        logic i;
        logic r;
        logic g;
        logic b;
    } irgb_t;

    typedef struct packed {
        irgb_t fg;
        irgb_t bg;
    } attr_t;

    localparam int MAX_CW = 16;

    function automatic int axis_total(vga_axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

    // Caller slices the low cw bits of the result.
    function automatic logic [MAX_CW-1:0] irgb_expand(
        logic c, logic i, int cw);
        logic [MAX_CW-1:0] ones;
        ones = MAX_CW'((32'd1 << cw) - 32'd1);
        unique case ({c, i})
            2'b11:   irgb_expand = ones;
            2'b10:   irgb_expand = ones >> 1;
            2'b01:   irgb_expand = ones >> 2;
            default: irgb_expand = '0;
        endcase
    endfunction

endpackage

// File: rtl/vga_text_renderer_if.sv
// Pixel-side read port of the character/attribute map and glyph
// memories.
interface vga_text_renderer_if
    import vga_text_pkg::*;
#(
    parameter int AW      = 13,
    parameter int CH_BITS = 8,
    parameter int GR_W    = 4,
    parameter int GLYPH_W = 8
);
    logic [AW-1:0]      map_addr_o;
    logic [CH_BITS-1:0] map_ch_i;
    attr_t              map_col_i;
    logic [CH_BITS-1:0] glyph_idx_o;
    logic [GR_W-1:0]    glyph_row_o;
    logic [GLYPH_W-1:0] glyph_bits_i;

    modport master (
        output map_addr_o, glyph_idx_o, glyph_row_o,
        input  map_ch_i, map_col_i, glyph_bits_i
    );

    modport slave (
        input  map_addr_o, glyph_idx_o, glyph_row_o,
        output map_ch_i, map_col_i, glyph_bits_i
    );
endinterface

// File: rtl/vga_text_renderer_timing.sv
// Horizontal/vertical raster counters with active, sync and
// frame-wrap flags.
module vga_timing_gen
    import vga_text_pkg::*;
#(
    parameter vga_axis_t H = H_DEF,
    parameter vga_axis_t V = V_DEF,
    localparam int HT = axis_total(H),
    localparam int VT = axis_total(V),
    localparam int HW = $clog2(HT),
    localparam int VW = $clog2(VT)
) (
    input  logic          clk_25m,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_wrap
);
    logic h_last;
    logic v_last;

    assign h_last = hcnt == HW'(HT - 1);
    assign v_last = vcnt == VW'(VT - 1);

    always_ff @(posedge clk_25m) begin
        if (rst || !en) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign active = (hcnt < HW'(H.active))
                 && (vcnt < VW'(V.active));
    assign hsync = (hcnt >= HW'(H.active + H.fp))
                && (hcnt < HW'(H.active + H.fp + H.sync));
    assign vsync = (vcnt >= VW'(V.active + V.fp))
                && (vcnt < VW'(V.active + V.fp + V.sync));
    assign frame_wrap = en && h_last && v_last;

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode pixel pipeline: map fetch, glyph lookup, cursor/blink,
// scroll and IRGB colour out, four cycles behind the raster.
module vga_text_renderer
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 16,
    parameter int CH_BITS = 8,
    parameter int COLOR_W = 4,
    parameter int BLINK_FRAMES = 32,
    parameter bit SYNC_ACTIVE = 1'b0,
    localparam int COLS = H_ACTIVE / GLYPH_W,
    localparam int ROWS = V_ACTIVE / GLYPH_H,
    localparam int AW = $clog2(COLS * ROWS),
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1,
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1
) (
    input  logic               clk_25m,
    input  logic               rst,
    input  logic               en_i,
    input  logic [RW-1:0]      scroll_row_i,
    input  logic               cursor_en_i,
    input  logic [CW-1:0]      cursor_col_i,
    input  logic [RW-1:0]      cursor_row_i,
    vga_text_renderer_if.master mem,
    output logic [COLOR_W-1:0] r_o,
    output logic [COLOR_W-1:0] g_o,
    output logic [COLOR_W-1:0] b_o,
    output logic               de_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               frame_start_o
);
    localparam int XB = $clog2(GLYPH_W);
    localparam int YB = $clog2(GLYPH_H);
    localparam vga_axis_t HA = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
    localparam vga_axis_t VA = '{V_ACTIVE, V_FP, V_SYNC, V_BP};
    localparam int HW = $clog2(axis_total(HA));
    localparam int VW = $clog2(axis_total(VA));
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    if (GLYPH_W < 2 || (GLYPH_W & (GLYPH_W - 1)) != 0) begin : g_bad_gw
        $error("GLYPH_W must be a power of two >= 2");
    end
    if (GLYPH_H < 2 || (GLYPH_H & (GLYPH_H - 1)) != 0) begin : g_bad_gh
        $error("GLYPH_H must be a power of two >= 2");
    end
    if (H_ACTIVE % GLYPH_W != 0 || V_ACTIVE % GLYPH_H != 0) begin : g_bad_fit
        $error("active area must be a whole number of cells");
    end
    if (COLOR_W < 2 || COLOR_W > MAX_CW) begin : g_bad_cw
        $error("COLOR_W out of range");
    end

    typedef struct packed {
        logic          act;
        logic          hs;
        logic          vs;
        logic          fs;
        logic          cur;
        logic [XB-1:0] xsub;
    } side_t;

    logic [HW-1:0]      hcnt;
    logic [VW-1:0]      vcnt;
    logic               active, hsync, vsync, frame_wrap;
    logic               origin;
    logic [CW-1:0]      col;
    logic [RW-1:0]      srow, scroll_shadow, scroll_eff, trow;
    logic [RW:0]        row_sum;
    logic [AW-1:0]      addr;
    logic [BW-1:0]      blink_cnt;
    logic               blink_phase;
    logic [CH_BITS-1:0] ch;
    side_t              s0, s1, s2, s3;
    logic [YB-1:0]      yrow1, yrow2;
    attr_t              attr3;
    logic               pix;
    irgb_t              color;

    vga_timing_gen #(.H(HA), .V(VA)) u_timing (
        .clk_25m    (clk_25m),
        .rst        (rst),
        .en         (en_i),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .active     (active),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_wrap (frame_wrap)
    );

    // The new scroll value applies from the very first fetch of a frame.
    assign origin     = hcnt == '0 && vcnt == '0;
    assign col        = hcnt[XB +: CW];
    assign srow       = vcnt[YB +: RW];
    assign scroll_eff = origin ? scroll_row_i : scroll_shadow;
    assign row_sum    = {1'b0, srow} + {1'b0, scroll_eff};
    assign trow = (row_sum >= (RW+1)'(ROWS))
                ? RW'(row_sum - (RW+1)'(ROWS)) : RW'(row_sum);
    assign addr = AW'(trow) * AW'(COLS) + AW'(col);

    always_comb begin
        s0      = '0;
        s0.act  = en_i && active;
        s0.hs   = en_i && hsync;
        s0.vs   = en_i && vsync;
        s0.fs   = en_i && origin;
        s0.cur  = cursor_en_i && blink_phase
               && col == cursor_col_i && srow == cursor_row_i
               && vcnt[YB-1:0] >= YB'(GLYPH_H - 2);
        s0.xsub = hcnt[XB-1:0];
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            scroll_shadow <= '0;
            blink_cnt     <= '0;
            blink_phase   <= 1'b0;
        end else begin
            if (origin)
                scroll_shadow <= scroll_row_i;
            if (frame_wrap) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign ch              = mem.map_ch_i;
    assign mem.glyph_idx_o = ch;
    assign mem.glyph_row_o = yrow2;

    assign pix   = mem.glyph_bits_i[XB'(GLYPH_W - 1) - s3.xsub];
    assign color = (pix || s3.cur) ? attr3.fg : attr3.bg;

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            s1             <= '0;
            s2             <= '0;
            s3             <= '0;
            yrow1          <= '0;
            yrow2          <= '0;
            attr3          <= '0;
            mem.map_addr_o <= '0;
            r_o            <= '0;
            g_o            <= '0;
            b_o            <= '0;
            de_o           <= 1'b0;
            frame_start_o  <= 1'b0;
            hsync_o        <= !SYNC_ACTIVE;
            vsync_o        <= !SYNC_ACTIVE;
        end else begin
            s1    <= s0;
            s2    <= s1;
            s3    <= s2;
            yrow1 <= vcnt[YB-1:0];
            yrow2 <= yrow1;
            attr3 <= mem.map_col_i;
            if (s0.act)
                mem.map_addr_o <= addr;
            de_o          <= s3.act;
            frame_start_o <= s3.fs;
            hsync_o       <= s3.hs ? SYNC_ACTIVE : !SYNC_ACTIVE;
            vsync_o       <= s3.vs ? SYNC_ACTIVE : !SYNC_ACTIVE;
            r_o <= s3.act
                 ? COLOR_W'(irgb_expand(color.r, color.i, COLOR_W)) : '0;
            g_o <= s3.act
                 ? COLOR_W'(irgb_expand(color.g, color.i, COLOR_W)) : '0;
            b_o <= s3.act
                 ? COLOR_W'(irgb_expand(color.b, color.i, COLOR_W)) : '0;
        end
    end

endmodule
